// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small input FIFO and a valid/ready byte handshake.
// Each bit lasts DIVISOR*OVERSAMPLE clocks; tx, tx_busy and tx_done are registered from the FSM state.
module uart_tx #(
    parameter int DIVISOR    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [7:0] din,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int BIT_CLKS = DIVISOR * OVERSAMPLE;
    localparam int CW = $clog2(BIT_CLKS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CLKS - 1);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [CW-1:0] r_baud;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit;
    logic          r_tx, r_ready, r_busy, r_done;
    logic          w_push, w_pop, w_baud_end;
    logic [AW:0]   w_count_nxt;

    assign w_push      = tx_valid && r_ready;
    assign w_baud_end  = r_baud == BAUD_LAST;
    // STOP pops on its last cycle so the next START follows with no idle gap
    assign w_pop       = r_count != '0 && (r_state == IDLE || (r_state == STOP && w_baud_end));
    assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    assign tx_ready = r_ready;
    assign tx       = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wptr] <= din;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= IDLE;
            r_baud  <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ready <= w_count_nxt != FULL;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_tx   <= r_state == START ? 1'b0 : r_state == DATA ? r_shift[0] : 1'b1;
            r_busy <= r_state != IDLE;
            r_done <= r_state == STOP && w_baud_end;
            // every state change other than IDLE->START happens on w_baud_end, so this clears on entry
            r_baud <= (r_state == IDLE || w_baud_end) ? '0 : r_baud + CW'(1);
            if (w_pop) begin
                r_shift <= r_mem[r_rptr];
                r_state <= START;
            end else if (w_baud_end) begin
                case (r_state)
                    START: begin
                        r_state <= DATA;
                        r_bit   <= '0;
                    end
                    DATA: begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= STOP;
                    end
                    STOP:    r_state <= IDLE;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed stimulus for uart_tx, checked every cycle against a
// frame-position model (byte queue + cycle offset into the current 10-bit frame).
module tb_uart_tx;
    localparam int B = 8, D = 4, FL = 10 * B;
    localparam logic [9:0] PAT_A5 = 10'b1101001010;

    logic       clk = 0, rstN = 1, tx_valid = 0;
    logic [7:0] din = 0;
    logic       tx_ready, tx, tx_busy, tx_done;
    int         tests = 0, fails = 0, dcount = 0, bcount = 0;

    uart_tx #(.DIVISOR(2), .OVERSAMPLE(4), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rstN(rstN), .din(din), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // line level of a frame carrying b, p clocks after the start bit began
    function automatic logic bitval(input logic [7:0] b, input int p);
        int k = p / B;
        return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
    endfunction

    logic [7:0] mq[$];
    logic [7:0] cur;
    logic       act = 0, e_tx = 1, e_busy = 0, e_done = 0, e_ready = 1;
    int         t = 0;

    // reference model: outputs visible after an edge reflect the frame position before it
    initial forever begin
        logic rdy;
        @(posedge clk);
        if (!rstN) begin
            mq.delete();
            act = 0; t = 0;
            e_tx = 1; e_busy = 0; e_done = 0; e_ready = 1;
        end else begin
            rdy    = mq.size() != D;
            e_tx   = act ? bitval(cur, t) : 1'b1;
            e_busy = act;
            e_done = act && t == FL - 1;
            if (act && t != FL - 1) t++;
            else if (mq.size() != 0) begin
                cur = mq.pop_front();
                act = 1;
                t   = 0;
            end else act = 0;
            if (tx_valid && rdy) mq.push_back(din);
            e_ready = mq.size() != D;
        end
        #1;
        check("m_tx", tx, e_tx);
        check("m_busy", tx_busy, e_busy);
        check("m_done", tx_done, e_done);
        check("m_ready", tx_ready, e_ready);
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (tx_done === 1'b1) dcount++;
        if (tx_busy === 1'b1) bcount++;
    end

    task automatic push(input logic [7:0] b);
        int  n = 0;
        logic r;
        tx_valid = 1;
        din = b;
        forever begin
            r = tx_ready;
            @(posedge clk);
            if (r) break;
            if (++n > 2000) begin
                tests++; fails++;
                $display("FAIL push_timeout: byte %h not accepted", b);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        tx_valid = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0, q = 0;
        while (q < 4 && n < 5000) begin
            @(negedge clk);
            n++;
            q = tx_busy ? 0 : q + 1;
        end
        tests++;
        if (q < 4) begin
            fails++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    logic txs[1:82], dns[1:82], bss[1:82];
    logic rd[6];
    int   acc, dsum;

    initial begin
        #2 rstN = 0;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        repeat (3) @(negedge clk);
        rstN = 1;
        repeat (100) @(negedge clk);
        check("idle_tx", tx, 1'b1);

        // single byte with hand-computed line pattern
        bcount = 0; dcount = 0;
        push(8'hA5);
        for (int i = 1; i <= 82; i++) begin
            @(posedge clk);
            #1;
            txs[i] = tx; dns[i] = tx_done; bss[i] = tx_busy;
        end
        check("lat_pre", txs[1], 1'b1);
        check("lat_low", txs[2], 1'b0);
        for (int k = 0; k < 10; k++) check($sformatf("a5_bit%0d", k), txs[6 + 8 * k], PAT_A5[k]);
        dsum = 0;
        for (int i = 1; i <= 82; i++) dsum += int'(dns[i]);
        check_int("a5_done_cnt", dsum, 1);
        check("a5_done_at80", dns[81], 1'b1);
        check("a5_busy_last", bss[81], 1'b1);
        check("a5_busy_fall", bss[82], 1'b0);
        wait_idle("a5_idle");
        check_int("a5_busy_cycles", bcount, FL);

        // back-to-back frames: busy must never drop between them
        bcount = 0; dcount = 0;
        foreach (PAT_A5[k]) ;
        push(8'hA5); push(8'h5A); push(8'hFF); push(8'h00);
        push(8'h12); push(8'h34); push(8'h56); push(8'h78);
        wait_idle("b2b_idle");
        check_int("b2b_done_cnt", dcount, 8);
        check_int("b2b_busy_cycles", bcount, 8 * FL);

        // FIFO full with tx_valid held 6 cycles
        bcount = 0; dcount = 0; acc = 0;
        tx_valid = 1;
        for (int i = 0; i < 6; i++) begin
            din = 8'($urandom);
            rd[i] = tx_ready;
            acc += int'(rd[i]);
            @(negedge clk);
        end
        tx_valid = 0;
        check_int("full_accepted", acc, 5);
        check("full_ready5", rd[4], 1'b1);
        check("full_ready6", rd[5], 1'b0);
        wait_idle("full_idle");
        check_int("full_done_cnt", dcount, 5);

        // reset during data bit 3 of 8'h34 with two bytes queued
        push(8'h34); push(8'($urandom)); push(8'($urandom));
        acc = 0;
        while (tx !== 1'b0 && acc < 100) begin
            @(negedge clk);
            acc++;
        end
        check("mid_start_seen", tx, 1'b0);
        repeat (8 + 24 + 3) @(negedge clk);
        rstN = 0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_ready", tx_ready, 1'b1);
        check("mid_rst_busy", tx_busy, 1'b0);
        repeat (2) @(negedge clk);
        rstN = 1;
        bcount = 0; dcount = 0;
        repeat (50) @(negedge clk);
        check_int("mid_no_frame_busy", bcount, 0);
        check_int("mid_no_frame_done", dcount, 0);

        // tx_valid held through tx_ready=0 with 8'h56
        for (int i = 0; i < 5; i++) push(8'($urandom));
        tx_valid = 1;
        din = 8'h56;
        check("held_ready_low", tx_ready, 1'b0);
        push(8'h56);
        wait_idle("held_idle");
        check_int("held_done_cnt", dcount, 6);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            tx_valid = $urandom_range(0, 3) == 0;
            din = 8'($urandom);
            @(negedge clk);
        end
        tx_valid = 0;
        wait_idle("rand_idle");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
